// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control unit: opcodes, fetch ALU opcode,
// sequencer state encoding and the instruction class produced by the decoder.
package cpu_defs;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] INC_OP = 5'b11111;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_RRR    = 3'd0,
    CLS_MULDIV = 3'd1,
    CLS_UNARY  = 3'd2,
    CLS_NOP    = 3'd3,
    CLS_HALT   = 3'd4,
    CLS_ILL    = 3'd5
  } op_class_e;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: maps IR[31:27] onto the execute-phase class.
module opcode_decode
  import cpu_defs::*;
(
  input  logic [OPW-1:0] opcode_i,
  output op_class_e      op_class_o
);

  // Classify the opcode; anything not recognised is illegal.
  always_comb begin
    op_class_o = CLS_ILL;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class_o = CLS_RRR;
      OP_MUL, OP_DIV:                 op_class_o = CLS_MULDIV;
      OP_NEG, OP_NOT:                 op_class_o = CLS_UNARY;
      OP_NOP:                         op_class_o = CLS_NOP;
      OP_HALT:                        op_class_o = CLS_HALT;
      default:                        op_class_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit sequencing the DataPath through fetch (T0-T2)
// and execute (T3-T6); strobes are a pure decode of state and opcode.
module control_sequencer
  import cpu_defs::*;
(
  input  logic           clock,
  input  logic           clear,
  input  logic           start,
  input  logic           mem_ready,
  input  logic [31:0]    ir,
  output logic           PCout,
  output logic           MARin,
  output logic           PCin,
  output logic           IncPC,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           ZlowIn,
  output logic           ZhighIn,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           LOin,
  output logic           HIin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           run,
  output logic           illegal
);

  state_e         state_q, state_d;
  logic           first_q, first_d;
  op_class_e      op_class_s;
  logic [OPW-1:0] opcode_s;
  logic           ir_unused_s;

  assign opcode_s = ir[31 -: OPW];
  // Register fields are consumed by the DataPath's select-and-encode logic.
  assign ir_unused_s = ^ir[31-OPW:0];

  opcode_decode u_decode (
    .opcode_i   (opcode_s),
    .op_class_o (op_class_s)
  );

  // State register and first-T1-cycle flag; clear abandons any instruction.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    first_d = (state_q == ST_T0);
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_T0;
        else       state_d = ST_IDLE;
      end
      ST_T0: state_d = ST_T1;
      ST_T1: begin
        if (mem_ready) state_d = ST_T2;
        else           state_d = ST_T1;
      end
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        case (op_class_s)
          CLS_RRR, CLS_MULDIV, CLS_UNARY: state_d = ST_T4;
          CLS_HALT:                       state_d = ST_HALT;
          default:                        state_d = ST_T0;
        endcase
      end
      ST_T4: begin
        case (op_class_s)
          CLS_RRR, CLS_MULDIV: state_d = ST_T5;
          default:             state_d = ST_T0;
        endcase
      end
      ST_T5: begin
        if (op_class_s == CLS_MULDIV) state_d = ST_T6;
        else                          state_d = ST_T0;
      end
      ST_T6: state_d = ST_T0;
      ST_HALT: begin
        if (start) state_d = ST_T0;
        else       state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe decode from present state and opcode class.
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZlowIn   = 1'b0;
    ZhighIn  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = 5'b00000;
    illegal  = 1'b0;
    run      = (state_q != ST_IDLE) && (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        alu_op = INC_OP;
        ZlowIn = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = first_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        case (op_class_s)
          CLS_RRR: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          CLS_MULDIV: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          CLS_UNARY: begin
            Grb    = 1'b1;
            Rout   = 1'b1;
            alu_op = opcode_s;
            ZlowIn = 1'b1;
          end
          CLS_ILL: illegal = 1'b1;
          default: illegal = 1'b0;
        endcase
      end
      ST_T4: begin
        case (op_class_s)
          CLS_RRR: begin
            Grc    = 1'b1;
            Rout   = 1'b1;
            alu_op = opcode_s;
            ZlowIn = 1'b1;
          end
          CLS_MULDIV: begin
            Grb     = 1'b1;
            Rout    = 1'b1;
            alu_op  = opcode_s;
            ZlowIn  = 1'b1;
            ZhighIn = 1'b1;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
          default: Rin = 1'b0;
        endcase
      end
      ST_T5: begin
        case (op_class_s)
          CLS_RRR: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
          CLS_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          default: Rin = 1'b0;
        endcase
      end
      ST_T6: begin
        if (op_class_s == CLS_MULDIV) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end else begin
          HIin     = 1'b0;
        end
      end
      default: run = run;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed and random instructions compared cycle by cycle
// against per-instruction strobe schedules built from the instruction-class rules.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin;
  logic ZlowIn, ZhighIn, Zlowout, Zhighout, LOin, HIin;
  logic Gra, Grb, Grc, Rin, Rout, run, illegal;
  logic [4:0] alu_op;

  control_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .PCin(PCin), .IncPC(IncPC), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZlowIn(ZlowIn),
    .ZhighIn(ZhighIn), .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin),
    .HIin(HIin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .run(run), .illegal(illegal)
  );

  always #5 clock = ~clock;

  logic [26:0] obs;
  assign obs = {PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin,
                ZlowIn, ZhighIn, Zlowout, Zhighout, LOin, HIin,
                Gra, Grb, Grc, Rin, Rout, alu_op, run, illegal};

  localparam logic [26:0] V_PCOUT  = 27'd1 << 26;
  localparam logic [26:0] V_MARIN  = 27'd1 << 25;
  localparam logic [26:0] V_PCIN   = 27'd1 << 24;
  localparam logic [26:0] V_READ   = 27'd1 << 22;
  localparam logic [26:0] V_MDRIN  = 27'd1 << 21;
  localparam logic [26:0] V_MDROUT = 27'd1 << 20;
  localparam logic [26:0] V_IRIN   = 27'd1 << 19;
  localparam logic [26:0] V_YIN    = 27'd1 << 18;
  localparam logic [26:0] V_ZLIN   = 27'd1 << 17;
  localparam logic [26:0] V_ZHIN   = 27'd1 << 16;
  localparam logic [26:0] V_ZLOUT  = 27'd1 << 15;
  localparam logic [26:0] V_ZHOUT  = 27'd1 << 14;
  localparam logic [26:0] V_LOIN   = 27'd1 << 13;
  localparam logic [26:0] V_HIIN   = 27'd1 << 12;
  localparam logic [26:0] V_GRA    = 27'd1 << 11;
  localparam logic [26:0] V_GRB    = 27'd1 << 10;
  localparam logic [26:0] V_GRC    = 27'd1 << 9;
  localparam logic [26:0] V_RIN    = 27'd1 << 8;
  localparam logic [26:0] V_ROUT   = 27'd1 << 7;
  localparam logic [26:0] V_RUN    = 27'd1 << 1;
  localparam logic [26:0] V_ILL    = 27'd1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [26:0] exp_q[$];

  function automatic logic [26:0] alu(input logic [4:0] op);
    return {20'd0, op, 2'd0};
  endfunction

  // Execute-phase schedule (T3 onwards) of one instruction, from its class.
  function automatic void build_exec(input logic [31:0] irv);
    logic [4:0] op;
    op = irv[31:27];
    exp_q.delete();
    if (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10}) begin
      exp_q.push_back(V_RUN | V_GRB | V_ROUT | V_YIN);
      exp_q.push_back(V_RUN | V_GRC | V_ROUT | alu(op) | V_ZLIN);
      exp_q.push_back(V_RUN | V_ZLOUT | V_GRA | V_RIN);
    end else if (op inside {5'd15, 5'd16}) begin
      exp_q.push_back(V_RUN | V_GRA | V_ROUT | V_YIN);
      exp_q.push_back(V_RUN | V_GRB | V_ROUT | alu(op) | V_ZLIN | V_ZHIN);
      exp_q.push_back(V_RUN | V_ZLOUT | V_LOIN);
      exp_q.push_back(V_RUN | V_ZHOUT | V_HIIN);
    end else if (op inside {5'd17, 5'd18}) begin
      exp_q.push_back(V_RUN | V_GRB | V_ROUT | alu(op) | V_ZLIN);
      exp_q.push_back(V_RUN | V_ZLOUT | V_GRA | V_RIN);
    end else if (op inside {5'd26, 5'd27}) begin
      exp_q.push_back(V_RUN);
    end else begin
      exp_q.push_back(V_RUN | V_ILL);
    end
  endfunction

  task automatic check(input logic [26:0] expv, input string tag);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Check the current cycle at the falling edge, then drive inputs for the next edge.
  task automatic cyc(input logic [26:0] expv, input logic mr, input logic st,
                     input logic [31:0] irv, input string tag);
    @(negedge clock);
    check(expv, tag);
    mem_ready = mr;
    start     = st;
    ir        = irv;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One full instruction starting in T0; ends with the machine about to enter T0.
  task automatic run_instr(input logic [31:0] irv, input int d, input int halt_wait,
                           input string tag);
    logic [26:0] sched[$];
    cyc(V_RUN | V_PCOUT | V_MARIN | alu(5'b11111) | V_ZLIN, rb(), rb(), irv,
        {tag, "_T0"});
    for (int i = 0; i <= d; i++)
      cyc(V_RUN | V_ZLOUT | V_READ | V_MDRIN | ((i == 0) ? V_PCIN : 27'd0),
          (i == d), rb(), irv, {tag, "_T1"});
    cyc(V_RUN | V_MDROUT | V_IRIN, rb(), rb(), irv, {tag, "_T2"});
    build_exec(irv);
    sched = exp_q;
    foreach (sched[k])
      cyc(sched[k], rb(), rb(), irv, $sformatf("%s_T%0d", tag, k + 3));
    if (irv[31:27] == 5'd27) begin
      for (int h = 0; h < halt_wait; h++)
        cyc(27'd0, rb(), 1'b0, irv, {tag, "_halt_wait"});
      cyc(27'd0, rb(), 1'b1, irv, {tag, "_halt_start"});
    end
  endtask

  initial begin
    logic [31:0] irv;
    logic [26:0] low;
    logic [4:0]  op;

    clear = 1'b0; start = 1'b1; mem_ready = 1'b1; ir = 32'd0;
    @(negedge clock);
    check(27'd0, "reset_outputs");
    @(negedge clock);
    check(27'd0, "reset_held_with_start");
    clear = 1'b1; start = 1'b0;
    cyc(27'd0, 1'b1, 1'b0, 32'd0, "idle_no_start");
    cyc(27'd0, 1'b1, 1'b1, 32'd0, "idle_start");

    run_instr(32'h8A800000, 0, 0, "neg");
    run_instr(32'h92800000, 0, 0, "not");
    run_instr(32'h18A50000, 3, 0, "add_wait3");
    run_instr(32'h78C48000, 0, 0, "mul");
    run_instr(32'hD8000000, 0, 3, "halt");
    run_instr(32'hE0000000, 1, 0, "illegal_11100");
    run_instr(32'hD0000000, 0, 0, "nop");
    run_instr(32'h80000000, 2, 0, "div");

    // Abandon a MUL in T4 with an asynchronous clear.
    irv = 32'h78000000;
    cyc(V_RUN | V_PCOUT | V_MARIN | alu(5'b11111) | V_ZLIN, 1'b1, 1'b0, irv, "clr_T0");
    cyc(V_RUN | V_ZLOUT | V_READ | V_MDRIN | V_PCIN, 1'b1, 1'b0, irv, "clr_T1");
    cyc(V_RUN | V_MDROUT | V_IRIN, 1'b1, 1'b0, irv, "clr_T2");
    cyc(V_RUN | V_GRA | V_ROUT | V_YIN, 1'b1, 1'b0, irv, "clr_T3");
    cyc(V_RUN | V_GRB | V_ROUT | alu(5'b01111) | V_ZLIN | V_ZHIN, 1'b1, 1'b0, irv, "clr_T4");
    clear = 1'b0;
    #1;
    check(27'd0, "clear_async");
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(27'd0, rb(), 1'b0, irv, "idle_after_clear");
    cyc(27'd0, rb(), 1'b1, irv, "idle_restart");

    for (int n = 0; n < 40; n++) begin
      op  = 5'($urandom_range(0, 31));
      low = 27'($urandom);
      irv = {op, low};
      run_instr(irv, $urandom_range(0, 3), $urandom_range(0, 2),
                $sformatf("rnd%0d_op%0d", n, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
